// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, memory freeze, MDU interlock.
// Controls are combinational from current hazards; only the MDU/wait/perf counters are registered.
module pipeline_hazard_ctrl #(
   parameter int MDU_LATENCY = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int PERF_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rt,
   input  logic              id_mdu_op,
   input  logic              id_reads_hilo,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rt,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              idex_we,
   output logic              exmem_we,
   output logic              memwb_we,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              mdu_start,
   output logic              mdu_busy,
   output logic [1:0]        stall_cause,
   output logic              mem_timeout,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [1:0] CAUSE_RUN      = 2'd0;
   localparam logic [1:0] CAUSE_LOAD_USE = 2'd1;
   localparam logic [1:0] CAUSE_MDU_WAIT = 2'd2;
   localparam logic [1:0] CAUSE_MEM_WAIT = 2'd3;

   localparam logic [5:0] MDU_LAT  = 6'(MDU_LATENCY);
   localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

   logic [5:0]        mdu_cnt_q, mdu_cnt_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

   logic memw;
   logic lu;
   logic mw;
   logic cnt_nz;

   always_comb begin
      cnt_nz = (mdu_cnt_q != 6'd0);
      memw   = mem_req & ~mem_ready;
      lu     = ex_memread & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
      mw     = cnt_nz & (id_mdu_op | id_reads_hilo);
   end

   // Priority: memory freeze, then branch squash, then load-use, then MDU interlock.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      mdu_start   = 1'b0;
      mdu_busy    = cnt_nz;
      stall_cause = CAUSE_RUN;
      if (rst) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_we    = 1'b0;
         exmem_we   = 1'b0;
         memwb_we   = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         mdu_busy   = 1'b0;
      end else if (memw) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_we    = 1'b0;
         stall_cause = CAUSE_MEM_WAIT;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu || mw) begin
         // Hold PC and IF/ID, inject a bubble into EX, let older stages drain.
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_flush  = 1'b1;
         stall_cause = lu ? CAUSE_LOAD_USE : CAUSE_MDU_WAIT;
      end else begin
         mdu_start = id_mdu_op;
      end
   end

   always_comb begin
      mdu_cnt_d = mdu_cnt_q;
      if (mdu_start) begin
         mdu_cnt_d = MDU_LAT;
      end else if (cnt_nz) begin
         mdu_cnt_d = mdu_cnt_q - 6'd1;
      end

      wait_cnt_d = 8'd0;
      if (memw) begin
         wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 8'd1;
      end

      // Report-only: the pipeline stays frozen until the memory answers.
      mem_timeout_d = mem_timeout_q | (memw & (wait_cnt_d == WAIT_MAX));

      stall_cycles_d = stall_cycles_q;
      if (!pc_we && (stall_cycles_q != {PERF_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mdu_cnt_q      <= 6'd0;
         wait_cnt_q     <= 8'd0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         mdu_cnt_q      <= mdu_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_pipeline_hazard_ctrl;

   localparam int LAT = 4;
   localparam int TO  = 8;
   localparam int PW  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, id_mdu_op, id_reads_hilo, ex_memread, ex_branch_taken, mem_req, mem_ready;
   logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush;
   logic       mdu_start, mdu_busy, mem_timeout;
   logic [1:0] stall_cause;
   logic [PW-1:0] stall_cycles;

   pipeline_hazard_ctrl #(.MDU_LATENCY(LAT), .MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_mdu_op(id_mdu_op), .id_reads_hilo(id_reads_hilo), .ex_memread(ex_memread),
      .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
      .stall_cause(stall_cause), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: remaining MDU cycles, consecutive wait cycles, sticky timeout, stall count.
   int m_cnt = 0, m_wait = 0, m_stall = 0;
   bit m_to = 1'b0;
   bit [4:0] e_we;
   bit [1:0] e_fl;
   bit e_start, e_busy;
   bit [1:0] e_cause;

   function automatic logic [4:0] dut_we();
      return {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
   endfunction

   task automatic model_eval();
      bit memw, lu, mw;
      memw = mem_req && !mem_ready;
      lu   = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
      mw   = (m_cnt > 0) && (id_mdu_op || id_reads_hilo);
      e_start = 0; e_cause = 0; e_busy = (m_cnt > 0);
      if (rst) begin
         e_we = 5'b00000; e_fl = 2'b11; e_busy = 0;
      end else if (memw) begin
         e_we = 5'b00000; e_fl = 2'b00; e_cause = 3;
      end else if (ex_branch_taken) begin
         e_we = 5'b11111; e_fl = 2'b11;
      end else if (lu) begin
         e_we = 5'b00111; e_fl = 2'b01; e_cause = 1;
      end else if (mw) begin
         e_we = 5'b00111; e_fl = 2'b01; e_cause = 2;
      end else begin
         e_we = 5'b11111; e_fl = 2'b00; e_start = id_mdu_op;
      end
   endtask

   task automatic model_commit();
      if (rst) begin
         m_cnt = 0; m_wait = 0; m_to = 0; m_stall = 0;
      end else begin
         if (e_start) m_cnt = LAT;
         else if (m_cnt > 0) m_cnt = m_cnt - 1;
         if (mem_req && !mem_ready) begin
            m_wait = (m_wait + 1 > TO) ? TO : m_wait + 1;
            if (m_wait == TO) m_to = 1;
         end else begin
            m_wait = 0;
         end
         if (e_we[4] == 0 && m_stall < (1 << PW) - 1) m_stall = m_stall + 1;
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_mdu_op = 0; id_reads_hilo = 0;
      ex_memread = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         {id_rs, id_rt, ex_rt} = 15'($urandom);
         {id_uses_rt, id_mdu_op, id_reads_hilo, ex_memread, ex_branch_taken, mem_req, mem_ready} = 7'($urandom);
         @(negedge clk);
         n_cmp++; if (dut_we() !== 5'b00000) begin n_bad++; $display("FAIL rst_we got %b want 00000", dut_we()); end
         n_cmp++; if ({ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cause} !== 6'b110000) begin
            n_bad++; $display("FAIL rst_ctl got %b want 110000", {ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cause}); end
         tick();
      end
      n_cmp++; if ({mem_timeout, stall_cycles} !== 17'd0) begin
         n_bad++; $display("FAIL rst_counters got to=%b stall=%0d want 0", mem_timeout, stall_cycles); end
      rst = 0; idle_inputs();
      @(negedge clk);
      n_cmp++; if (dut_we() !== 5'b11111 || stall_cause !== 2'd0) begin
         n_bad++; $display("FAIL rst_release got we=%b cause=%0d want 11111/0", dut_we(), stall_cause); end
      tick();
   endtask

   task automatic test_load_use();
      ex_memread = 1; ex_rt = 5; id_rs = 5;
      @(negedge clk);
      n_cmp++; if ({pc_we, ifid_we, idex_flush, stall_cause} !== 5'b00101) begin
         n_bad++; $display("FAIL lu_stall got pc=%b ifid=%b idf=%b cause=%0d want 0/0/1/1", pc_we, ifid_we, idex_flush, stall_cause); end
      tick();
      n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cycles got %0d want 1", stall_cycles); end
      ex_rt = 0; id_rs = 0;
      @(negedge clk);
      n_cmp++; if (pc_we !== 1'b1 || stall_cause !== 2'd0) begin
         n_bad++; $display("FAIL lu_r0 got pc=%b cause=%0d want 1/0", pc_we, stall_cause); end
      tick();
      ex_rt = 5; id_rs = 3; id_rt = 5; id_uses_rt = 0;
      @(negedge clk);
      n_cmp++; if (pc_we !== 1'b1 || stall_cause !== 2'd0) begin
         n_bad++; $display("FAIL lu_rt_unused got pc=%b cause=%0d want 1/0", pc_we, stall_cause); end
      tick();
      id_uses_rt = 1;
      @(negedge clk);
      n_cmp++; if (pc_we !== 1'b0 || stall_cause !== 2'd1) begin
         n_bad++; $display("FAIL lu_rt_used got pc=%b cause=%0d want 0/1", pc_we, stall_cause); end
      tick();
      idle_inputs();
   endtask

   task automatic test_mdu();
      id_mdu_op = 1;
      @(negedge clk);
      n_cmp++; if ({mdu_start, mdu_busy, stall_cause} !== 4'b1000) begin
         n_bad++; $display("FAIL mdu_launch got start=%b busy=%b cause=%0d want 1/0/0", mdu_start, mdu_busy, stall_cause); end
      tick();
      id_mdu_op = 0; id_reads_hilo = 1;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         n_cmp++; if ({mdu_busy, stall_cause, pc_we, idex_flush, mdu_start} !== 6'b110010) begin
            n_bad++; $display("FAIL mdu_wait_%0d got busy=%b cause=%0d pc=%b idf=%b start=%b want 1/2/0/1/0",
                              k, mdu_busy, stall_cause, pc_we, idex_flush, mdu_start); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if ({mdu_busy, pc_we, stall_cause} !== 4'b0100) begin
         n_bad++; $display("FAIL mdu_done got busy=%b pc=%b cause=%0d want 0/1/0", mdu_busy, pc_we, stall_cause); end
      tick();
      idle_inputs();
   endtask

   task automatic test_branch_vs_lu();
      ex_memread = 1; ex_rt = 9; id_rs = 9; ex_branch_taken = 1; id_mdu_op = 1;
      @(negedge clk);
      n_cmp++; if ({dut_we(), ifid_flush, idex_flush, mdu_start, stall_cause} !== 10'b1111111000) begin
         n_bad++; $display("FAIL branch_prio got we=%b fl=%b%b start=%b cause=%0d want 11111/11/0/0",
                           dut_we(), ifid_flush, idex_flush, mdu_start, stall_cause); end
      tick();
      idle_inputs();
      @(negedge clk);
      n_cmp++; if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL branch_squash_mdu got busy=%b want 0", mdu_busy); end
      tick();
   endtask

   task automatic test_mem_wait();
      id_mdu_op = 1;
      tick();
      mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++; if ({dut_we(), ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cause} !== 11'b00000000111) begin
            n_bad++; $display("FAIL memw_%0d got we=%b fl=%b%b start=%b busy=%b cause=%0d want 00000/00/0/1/3",
                              k, dut_we(), ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cause); end
         tick();
      end
      mem_ready = 1; id_mdu_op = 0;
      @(negedge clk);
      n_cmp++; if ({dut_we(), ifid_flush, idex_flush, mdu_busy} !== 8'b11111111) begin
         n_bad++; $display("FAIL memw_release got we=%b fl=%b%b busy=%b want 11111/11/1", dut_we(), ifid_flush, idex_flush, mdu_busy); end
      tick();
      idle_inputs();
      @(negedge clk);
      n_cmp++; if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL memw_cnt_drained got busy=%b want 0", mdu_busy); end
      n_cmp++; if (stall_cycles !== PW'(m_stall)) begin
         n_bad++; $display("FAIL memw_stall_cycles got %0d want %0d", stall_cycles, m_stall); end
      tick();
   endtask

   task automatic test_timeout();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_timeout !== (i >= TO) || stall_cause !== 2'd3) begin
            n_bad++; $display("FAIL timeout_wait_%0d got to=%b cause=%0d want %b/3", i, mem_timeout, stall_cause, i >= TO); end
         tick();
      end
      mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_timeout !== 1'b1 || pc_we !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky_%0d got to=%b pc=%b want 1/1", i, mem_timeout, pc_we); end
         tick();
      end
      rst = 1; tick(); rst = 0; idle_inputs();
      @(negedge clk);
      n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_clear got %b want 0", mem_timeout); end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst             = ($urandom_range(0, 99) < 2);
         id_rs           = 5'($urandom_range(0, 7));
         id_rt           = 5'($urandom_range(0, 7));
         ex_rt           = 5'($urandom_range(0, 7));
         id_uses_rt      = 1'($urandom);
         id_mdu_op       = ($urandom_range(0, 99) < 20);
         id_reads_hilo   = ($urandom_range(0, 99) < 25);
         ex_memread      = ($urandom_range(0, 99) < 30);
         ex_branch_taken = ($urandom_range(0, 99) < 15);
         mem_req         = ($urandom_range(0, 99) < 40);
         mem_ready       = ($urandom_range(0, 99) < 50);
         @(negedge clk);
         model_eval();
         n_cmp++; if ({dut_we(), ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cause} !== {e_we, e_fl, e_start, e_busy, e_cause}) begin
            n_bad++; $display("FAIL rand_ctl_%0d got %b want %b", c,
                              {dut_we(), ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cause},
                              {e_we, e_fl, e_start, e_busy, e_cause}); end
         tick();
         n_cmp++; if (mem_timeout !== m_to || stall_cycles !== PW'(m_stall)) begin
            n_bad++; $display("FAIL rand_cnt_%0d got to=%b stall=%0d want %b/%0d", c, mem_timeout, stall_cycles, m_to, m_stall); end
      end
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      #1;
      test_reset();
      test_load_use();
      test_mdu();
      test_branch_vs_lu();
      test_mem_wait();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
